// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo
//   Multicycle RV32I control FSM. Sequences a shared datapath (PC, IR, OldPC,
//   register file, ALU, ALUOut, Data register, unified instruction/data memory)
//   through fetch / decode / execute / memory / writeback states.
//   Supported: lw, sw, R-type, I-type ALU, beq/bne/blt/bge/bltu/bgeu, jal.
//   Any other opcode (or a branch with funct3 010/011) parks the FSM in ILLEGAL
//   until reset.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   op, funct3, funct7b5       instruction fields from IR
//   zero, lt, ltu              ALU compare flags
//   mem_ready                  memory handshake completion (ignored without mem_req)
//   mem_req, mem_write         memory request / request is a write
//   adr_src                    memory address mux (0 PC, 1 ALUOut)
//   ir_write, pc_write         IR+OldPC load, PC load
//   reg_write                  register-file write enable
//   alu_src_a/b, imm_src       datapath mux selects, immediate format
//   result_src, alu_ctrl       result mux, ALU operation
//   state                      current state code (debug)
//   instr_retired              one-cycle pulse when an instruction completes
//   illegal                    trap flag, held until reset
//   cycle_cnt, instret_cnt     performance counters
//
// Build option
//   UC_PERF_CNT_EN  when defined, cycle_cnt / instret_cnt count cycles out of
//                   reset and retired instructions; otherwise both are tied 0.

module unidade_controle_multiciclo #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [1:0]       result_src,
  output logic [3:0]       alu_ctrl,
  output logic [3:0]       state,
  output logic             instr_retired,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  state_t st, nx;

  // Raw (pre-reset-gating) enables
  logic mreq, mwr, irw, pcw, rw, ret, ill;

  // funct7b5 selects sub only for register ops; for immediates bit 30 is
  // part of the immediate except on srai.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic b5,
                                         input logic is_reg);
    case (f3)
      3'b000:  alu_dec = (is_reg && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) st <= S_FETCH;
    else       st <= nx;
  end

  always_comb begin
    nx         = st;
    mreq       = 1'b0;
    mwr        = 1'b0;
    adr_src    = 1'b0;
    irw        = 1'b0;
    pcw        = 1'b0;
    rw         = 1'b0;
    ret        = 1'b0;
    ill        = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 2'b00;
    result_src = 2'b00;
    alu_ctrl   = ALU_ADD;
    case (st)
      S_FETCH: begin
        // PC+4 goes straight from ALUResult into PC while IR loads
        mreq       = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        irw        = mem_ready;
        pcw        = mem_ready;
        if (mem_ready) nx = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jump target OldPC+imm is parked in ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_JAL) ? 2'b11 : 2'b10;
        case (op)
          OP_LW, OP_SW: nx = S_MEMADR;
          OP_R:         nx = S_EXECR;
          OP_I:         nx = S_EXECI;
          OP_BR:        nx = S_BRANCH;
          OP_JAL:       nx = S_JAL;
          default:      nx = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (op == OP_SW) begin
          imm_src = 2'b01;
          nx      = S_MEMWRITE;
        end else begin
          nx      = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        mreq    = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) nx = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        rw         = 1'b1;
        ret        = 1'b1;
        nx         = S_FETCH;
      end
      S_MEMWRITE: begin
        mreq    = 1'b1;
        mwr     = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          ret = 1'b1;
          nx  = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_dec(funct3, funct7b5, 1'b1);
        nx        = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_dec(funct3, funct7b5, 1'b0);
        nx        = S_ALUWB;
      end
      S_ALUWB: begin
        rw  = 1'b1;
        ret = 1'b1;
        nx  = S_FETCH;
      end
      S_JAL: begin
        // PC <= target from ALUOut while ALU forms the link value OldPC+4
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pcw       = 1'b1;
        nx        = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        nx        = S_FETCH;
        ret       = 1'b1;
        case (funct3)
          3'b000:  pcw = zero;
          3'b001:  pcw = ~zero;
          3'b100:  pcw = lt;
          3'b101:  pcw = ~lt;
          3'b110:  pcw = ltu;
          3'b111:  pcw = ~ltu;
          default: begin
            ret = 1'b0;
            nx  = S_ILLEGAL;
          end
        endcase
      end
      S_ILLEGAL: ill = 1'b1;
      default:   nx  = S_ILLEGAL;
    endcase
  end

  // Reset wins over every enable in the same cycle, including mid-access
  assign mem_req       = mreq & ~reset;
  assign mem_write     = mwr  & ~reset;
  assign ir_write      = irw  & ~reset;
  assign pc_write      = pcw  & ~reset;
  assign reg_write     = rw   & ~reset;
  assign instr_retired = ret  & ~reset;
  assign illegal       = ill  & ~reset;
  assign state         = st;

`ifdef UC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (instr_retired) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
